// File: rtl/imem_arbiter.sv
// Two-port arbiter for a single-port instruction memory: core fetch (read-only)
// and loader/debug (read/write), round-robin with loader lock and 1-cycle responses.
module imem_arbiter #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          fetch_req_i,
  input  logic [31:0]   fetch_addr_i,
  output logic          fetch_gnt_o,
  output logic          fetch_rvalid_o,
  output logic [31:0]   fetch_rdata_o,
  output logic          fetch_err_o,
  input  logic          ld_req_i,
  input  logic          ld_we_i,
  input  logic [31:0]   ld_addr_i,
  input  logic [31:0]   ld_wdata_i,
  input  logic          ld_lock_i,
  output logic          ld_gnt_o,
  output logic          ld_rvalid_o,
  output logic [31:0]   ld_rdata_o,
  output logic          ld_err_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i
);

  typedef enum logic {StUnlocked, StLocked} lock_e;

  lock_e lock_q, lock_d;
  logic  last_ld_q, last_ld_d;
  logic  resp_valid_q, resp_valid_d;
  logic  resp_ld_q, resp_ld_d;
  logic  resp_err_q, resp_err_d;
  logic  resp_write_q, resp_write_d;

  logic  lock_hold;
  logic  fetch_bad, ld_bad, win_bad, any_gnt, rd_ok;

  // Misaligned or beyond the last word of the array.
  function automatic logic addr_bad(input logic [31:0] a);
    logic [31:0] hi;
    hi = a >> (AW + 2);
    return (a[1:0] != 2'b00) || (hi != 32'd0);
  endfunction

  always_comb begin
    fetch_gnt_o = 1'b0;
    ld_gnt_o    = 1'b0;
    // Dropping ld_lock_i releases fetch in the same cycle.
    lock_hold   = (lock_q == StLocked) && ld_lock_i;
    if (rst_ni) begin
      if (lock_hold) begin
        ld_gnt_o = ld_req_i;
      end else if (fetch_req_i && ld_req_i) begin
        fetch_gnt_o = last_ld_q;
        ld_gnt_o    = ~last_ld_q;
      end else begin
        fetch_gnt_o = fetch_req_i;
        ld_gnt_o    = ld_req_i;
      end
    end
  end

  always_comb begin
    fetch_bad   = addr_bad(fetch_addr_i);
    ld_bad      = addr_bad(ld_addr_i);
    win_bad     = ld_gnt_o ? ld_bad : fetch_bad;
    any_gnt     = fetch_gnt_o | ld_gnt_o;
    mem_req_o   = any_gnt & ~win_bad;
    mem_we_o    = mem_req_o & ld_gnt_o & ld_we_i;
    mem_addr_o  = '0;
    if (mem_req_o) begin
      mem_addr_o = ld_gnt_o ? ld_addr_i[AW+1:2] : fetch_addr_i[AW+1:2];
    end
    mem_wdata_o = mem_we_o ? ld_wdata_i : 32'd0;
  end

  always_comb begin
    last_ld_d    = any_gnt ? ld_gnt_o : last_ld_q;
    lock_d       = lock_q;
    case (lock_q)
      StUnlocked: if (ld_gnt_o && ld_lock_i) lock_d = StLocked;
      StLocked:   if (!ld_lock_i) lock_d = StUnlocked;
      default:    lock_d = StUnlocked;
    endcase
    resp_valid_d = any_gnt;
    resp_ld_d    = ld_gnt_o;
    resp_err_d   = any_gnt & win_bad;
    resp_write_d = ld_gnt_o & ld_we_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q       <= StUnlocked;
      last_ld_q    <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_ld_q    <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_write_q <= 1'b0;
    end else begin
      lock_q       <= lock_d;
      last_ld_q    <= last_ld_d;
      resp_valid_q <= resp_valid_d;
      resp_ld_q    <= resp_ld_d;
      resp_err_q   <= resp_err_d;
      resp_write_q <= resp_write_d;
    end
  end

  always_comb begin
    rd_ok          = resp_valid_q & ~resp_err_q & ~resp_write_q;
    fetch_rvalid_o = resp_valid_q & ~resp_ld_q;
    ld_rvalid_o    = resp_valid_q & resp_ld_q;
    fetch_err_o    = fetch_rvalid_o & resp_err_q;
    ld_err_o       = ld_rvalid_o & resp_err_q;
    fetch_rdata_o  = (fetch_rvalid_o && rd_ok) ? mem_rdata_i : 32'd0;
    ld_rdata_o     = (ld_rvalid_o && rd_ok) ? mem_rdata_i : 32'd0;
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed vector table, corner sequences,
// then constrained-random traffic against a transaction-level reference model.
module tb_imem_arbiter;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fetch_req = 1'b0;
  logic [31:0]   fetch_addr = '0;
  logic          fetch_gnt, fetch_rvalid, fetch_err;
  logic [31:0]   fetch_rdata;
  logic          ld_req = 1'b0, ld_we = 1'b0, ld_lock = 1'b0;
  logic [31:0]   ld_addr = '0, ld_wdata = '0;
  logic          ld_gnt, ld_rvalid, ld_err;
  logic [31:0]   ld_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;

  imem_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_gnt_o(fetch_gnt),
    .fetch_rvalid_o(fetch_rvalid), .fetch_rdata_o(fetch_rdata), .fetch_err_o(fetch_err),
    .ld_req_i(ld_req), .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata),
    .ld_lock_i(ld_lock), .ld_gnt_o(ld_gnt), .ld_rvalid_o(ld_rvalid), .ld_rdata_o(ld_rdata),
    .ld_err_o(ld_err), .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory array attached to the DUT.
  logic [31:0] tbmem [DEPTH];
  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) tbmem[mem_addr] <= mem_wdata;
      else        mem_rdata <= tbmem[mem_addr];
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state: transaction-level view of the arbiter and memory.
  logic [31:0] ref_mem [DEPTH];
  logic        m_last_ld, m_locked, m_efg, m_elg;
  logic        p_valid, p_ld, p_err;
  logic [31:0] p_data;

  function automatic logic is_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
  endfunction

  task automatic model_reset();
    m_last_ld = 1'b1; m_locked = 1'b0; m_efg = 1'b0; m_elg = 1'b0;
    p_valid = 1'b0; p_ld = 1'b0; p_err = 1'b0; p_data = '0;
  endtask

  task automatic cycle(input logic fr, input logic [31:0] fa, input logic lr, input logic lw,
                       input logic [31:0] la, input logic [31:0] lwd, input logic lk);
    logic f_bad, l_bad, e_req, e_we;
    logic [31:0] e_addr, e_wd;
    @(negedge clk);
    fetch_req = fr; fetch_addr = fa; ld_req = lr; ld_we = lw;
    ld_addr = la; ld_wdata = lwd; ld_lock = lk;
    #1;
    if (m_locked && lk) begin
      m_efg = 1'b0; m_elg = lr;
    end else if (fr && lr) begin
      m_efg = m_last_ld; m_elg = !m_last_ld;
    end else begin
      m_efg = fr; m_elg = lr;
    end
    f_bad = is_bad(fa); l_bad = is_bad(la);
    e_req = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
    if (m_efg && !f_bad) begin e_req = 1'b1; e_addr = fa >> 2; end
    if (m_elg && !l_bad) begin e_req = 1'b1; e_we = lw; e_addr = la >> 2; e_wd = lwd; end
    chk("fetch_gnt", fetch_gnt, m_efg);
    chk("ld_gnt", ld_gnt, m_elg);
    chk("mem_req", mem_req, e_req);
    chk("mem_we", mem_we, e_we);
    if (e_req || !(m_efg || m_elg)) chk("mem_addr", 32'(mem_addr), e_addr);
    if (e_we || !(m_efg || m_elg)) chk("mem_wdata", mem_wdata, e_wd);
    chk("fetch_rvalid", fetch_rvalid, p_valid && !p_ld);
    chk("fetch_err", fetch_err, p_valid && !p_ld && p_err);
    chk("fetch_rdata", fetch_rdata, (p_valid && !p_ld) ? p_data : 32'd0);
    chk("ld_rvalid", ld_rvalid, p_valid && p_ld);
    chk("ld_err", ld_err, p_valid && p_ld && p_err);
    chk("ld_rdata", ld_rdata, (p_valid && p_ld) ? p_data : 32'd0);
    // Advance the model across the coming rising edge.
    if (m_efg || m_elg) m_last_ld = m_elg;
    m_locked = m_locked ? lk : (m_elg && lk);
    p_valid = m_efg || m_elg;
    p_ld = m_elg;
    p_err = m_elg ? l_bad : (m_efg && f_bad);
    if (!p_valid || p_err) p_data = '0;
    else if (m_elg && lw) begin p_data = '0; ref_mem[la[AW+1:2]] = lwd; end
    else if (m_elg) p_data = ref_mem[la[AW+1:2]];
    else p_data = ref_mem[fa[AW+1:2]];
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_fetch_gnt"}, fetch_gnt, 0);
    chk({tag, "_ld_gnt"}, ld_gnt, 0);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_fetch_rvalid"}, fetch_rvalid, 0);
    chk({tag, "_fetch_err"}, fetch_err, 0);
    chk({tag, "_fetch_rdata"}, fetch_rdata, 0);
    chk({tag, "_ld_rvalid"}, ld_rvalid, 0);
    chk({tag, "_ld_err"}, ld_err, 0);
    chk({tag, "_ld_rdata"}, ld_rdata, 0);
  endtask

  typedef struct {
    logic fr; logic [31:0] fa; logic lr; logic lw; logic [31:0] la; logic [31:0] lwd;
    logic lk; logic efg; logic elg;
  } vec_t;
  vec_t vt[$];

  task automatic add(input logic fr, input logic [31:0] fa, input logic lr, input logic lw,
                     input logic [31:0] la, input logic [31:0] lwd, input logic lk,
                     input logic efg, input logic elg);
    vec_t v;
    v.fr = fr; v.fa = fa; v.lr = lr; v.lw = lw; v.la = la; v.lwd = lwd; v.lk = lk;
    v.efg = efg; v.elg = elg;
    vt.push_back(v);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0:       a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
      1:       a = 32'(DEPTH * 4) + (32'($urandom_range(0, 1023)) << 2);
      default: a = 32'($urandom_range(0, DEPTH - 1)) << 2;
    endcase
    return a;
  endfunction

  logic        r_fr, r_lr, r_lw, r_lk;
  logic [31:0] r_fa, r_la, r_lwd;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      tbmem[i] = 32'(i * 32'h11);
      ref_mem[i] = 32'(i * 32'h11);
    end
    model_reset();
    fetch_req = 1'b1; ld_req = 1'b1; ld_we = 1'b1;
    #12;
    chk_all_zero("rst");
    @(negedge clk);
    rst_n = 1'b1; fetch_req = 1'b0; ld_req = 1'b0; ld_we = 1'b0;

    // Fetch stream, round robin, loader lock.
    add(1, 32'h0, 0, 0, 32'h0, 32'h0, 0, 1, 0);
    add(1, 32'h4, 0, 0, 32'h0, 32'h0, 0, 1, 0);
    add(1, 32'h8, 0, 0, 32'h0, 32'h0, 0, 1, 0);
    add(0, 32'h0, 1, 0, 32'h10, 32'h0, 0, 0, 1);
    add(1, 32'h10, 1, 0, 32'h10, 32'h0, 0, 1, 0);
    add(1, 32'h10, 1, 0, 32'h10, 32'h0, 0, 0, 1);
    add(1, 32'h10, 1, 0, 32'h10, 32'h0, 0, 1, 0);
    add(1, 32'h10, 1, 0, 32'h10, 32'h0, 0, 0, 1);
    add(0, 32'h0, 1, 1, 32'h0, 32'hDEADBEEF, 1, 0, 1);
    add(1, 32'h4, 1, 1, 32'h4, 32'h12345678, 1, 0, 1);
    add(1, 32'h4, 0, 0, 32'h0, 32'h0, 1, 0, 0);
    add(1, 32'h4, 0, 0, 32'h0, 32'h0, 1, 0, 0);
    add(1, 32'h4, 0, 0, 32'h0, 32'h0, 0, 1, 0);
    add(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    for (int i = 0; i < vt.size(); i++) begin
      cycle(vt[i].fr, vt[i].fa, vt[i].lr, vt[i].lw, vt[i].la, vt[i].lwd, vt[i].lk);
      chk($sformatf("vec%0d_fetch_gnt", i), fetch_gnt, vt[i].efg);
      chk($sformatf("vec%0d_ld_gnt", i), ld_gnt, vt[i].elg);
    end
    chk("lock_fetch_rdata", fetch_rdata, 32'h12345678);

    // Misaligned fetch, out-of-range write.
    cycle(1, 32'h102, 0, 0, 32'h0, 32'h0, 0);
    chk("err_fetch_gnt", fetch_gnt, 1);
    chk("err_mem_req", mem_req, 0);
    idle();
    chk("err_fetch_err", fetch_err, 1);
    chk("err_fetch_rdata", fetch_rdata, 0);
    cycle(0, 32'h0, 1, 1, 32'h100, 32'h0BAD0BAD, 0);
    chk("oor_mem_req", mem_req, 0);
    cycle(0, 32'h0, 1, 0, 32'h0, 32'h0, 0);
    chk("oor_ld_err", ld_err, 1);
    idle();
    chk("oor_word0", ld_rdata, 32'hDEADBEEF);

    // Write acknowledge then read-back.
    cycle(0, 32'h0, 1, 1, 32'h20, 32'hCAFEF00D, 0);
    cycle(0, 32'h0, 1, 0, 32'h20, 32'h0, 0);
    chk("wack_rvalid", ld_rvalid, 1);
    chk("wack_rdata", ld_rdata, 0);
    chk("wack_err", ld_err, 0);
    idle();
    chk("wack_readback", ld_rdata, 32'hCAFEF00D);

    // Reset right after a fetch grant drops the pending response.
    cycle(1, 32'h8, 0, 0, 32'h0, 32'h0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0; ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h4;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("midrst_fetch_rvalid", fetch_rvalid, 0);
    @(negedge clk);
    rst_n = 1'b1; fetch_req = 1'b0; ld_req = 1'b0; ld_we = 1'b0;
    model_reset();
    cycle(1, 32'h10, 1, 0, 32'h10, 32'h0, 0);
    chk("postrst_first_conflict", fetch_gnt, 1);
    idle();

    // Random traffic honouring hold-until-granted.
    r_fr = 1'b0; r_lr = 1'b0; r_fa = '0; r_la = '0; r_lw = 1'b0; r_lwd = '0;
    m_efg = 1'b0; m_elg = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!(r_fr && !m_efg)) begin
        r_fr = ($urandom_range(0, 3) != 0);
        r_fa = rand_addr();
      end
      if (!(r_lr && !m_elg)) begin
        r_lr = ($urandom_range(0, 2) != 0);
        r_lw = 1'($urandom_range(0, 1));
        r_la = rand_addr();
        r_lwd = $urandom;
      end
      r_lk = ($urandom_range(0, 9) < 3);
      cycle(r_fr, r_fa, r_lr, r_lw, r_la, r_lwd, r_lk);
    end
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
